tqvp_pdm_out: RTL and testbench
===============================

TQVP_PDM_OUT -- requirements
Module: tqvp_pdm_out

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, signed integrator sample width.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sample_data  input  SAMPLE_W  two's-complement integrator output.
REQ-005 SHALL have port sample_valid  input  1  sample_data valid this cycle.
REQ-006 SHALL have port sample_ready  output  1  holding register empty; transfer on valid&ready.
REQ-007 SHALL have port address  input  4  register address from SPI register bridge.
REQ-008 SHALL have port data_in  input  8  register write data.
REQ-009 SHALL have port data_write  input  1  one-cycle write strobe.
REQ-010 SHALL have port data_out  output  8  register read data, combinational on address.
REQ-011 SHALL have port pdm_out  output  1  registered pulse-density output.

Function
REQ-012 SHALL decode registers: 0x0 CTRL (bit0 EN, bit1 INV, bits4:2 SHIFT), 0x1 PRESC, 0x2 STATUS (RO: bit0 FULL, bit1 UNDERRUN), 0x3 LEVEL[7:0], 0x4 LEVEL[15:8]; other addresses read 0x00, writes ignored.
REQ-013 SHALL clear UNDERRUN on any write to 0x2; writes to 0x3/0x4 ignored.
REQ-014 SHALL hold a one-entry holding register; sample_ready is registered and equals NOT FULL.
REQ-015 SHALL set FULL the cycle after valid&ready; when FULL, sample_valid is ignored.
REQ-016 SHALL generate tick when prescale counter equals PRESC, then reload counter to 0; tick period = PRESC+1 clocks.
REQ-017 SHALL reset the counter to 0 on any PRESC write; tick not asserted that cycle.
REQ-018 SHALL on tick with FULL: move holding sample to active level and clear FULL (sample_ready high next cycle).
REQ-019 SHALL on tick with FULL=0 after at least one load since reset: retain active level and set UNDERRUN (sticky).
REQ-020 SHALL compute level = saturate16(sample << SHIFT) XOR 0x8000 (offset binary); saturation to 0x7FFF / 0x8000 on overflow.
REQ-021 SHALL on each tick update 16-bit accumulator: {carry, acc} = acc + level; pdm_out <= carry XOR INV on the same edge.
REQ-022 SHALL hold pdm_out between ticks (one pulse width = PRESC+1 clocks).
REQ-023 SHALL when EN=0: counter held 0, no ticks, acc = 0, pdm_out = INV; holding register still accepts one sample.
REQ-024 SHALL give simultaneous tick and data_write to 0x2: UNDERRUN set wins over clear.
REQ-025 SHALL take effect of CTRL write on the next tick (SHIFT applied at transfer time).
REQ-026 SHALL guarantee density: level 0x0000 -> pdm_out constant 0; level 0xFFFF -> exactly one 0 per 65536 ticks (INV=0).

Reset
REQ-027 SHALL on rst: CTRL=0x00, PRESC=0x00, FULL=0, UNDERRUN=0, load-seen=0, active level=0x8000, acc=0, counter=0, pdm_out=0, sample_ready=0 in reset cycle then 1.
REQ-028 SHALL abort any in-flight sample on rst mid-operation; no transfer on the reset cycle.

Structure
REQ-029 SHALL place register addresses, CTRL bit positions and SAMPLE_W default in shared package tqvp_pdm_pkg.
REQ-030 SHALL implement shift-and-saturate as combinational sub-module tqvp_pdm_sat; everything else in tqvp_pdm_out.
REQ-031 SHALL be 120-400 lines of RTL total, no memories, no additional clocks.

Verification
REQ-032 SHALL test: reset -> data_out at 0x0..0x4 reads 00,00,00,00,80; pdm_out=0; sample_ready=1 one cycle after reset release.
REQ-033 SHALL test: EN=1, PRESC=3, SHIFT=0, sample 0x0000 -> level 0x8000, pdm_out toggles each tick (period 8 clocks), FULL clears at first tick.
REQ-034 SHALL test: SHIFT=2, sample 0x4000 -> LEVEL reads 0xFFFF (saturated); sample 0xC000 -> LEVEL 0x0000; pdm_out constant 0.
REQ-035 SHALL test: no new sample after first load, PRESC=0 -> STATUS=0x02 after second tick; write 0x2 -> reads 0x00; same-cycle tick+clear -> 0x02.
REQ-036 SHALL test: PRESC written mid-count (counter=5, new PRESC=2) -> next tick exactly 3 clocks after write.
REQ-037 SHALL test: INV=1, EN=0 -> pdm_out=1; rst asserted while FULL=1 -> FULL=0, level 0x8000, no tick for PRESC+1 clocks after EN=1.

Source files
------------

// File: rtl/tqvp_pdm_pkg.sv
// Shared definitions for the PDM audio output peripheral: register map,
// CTRL field positions and the offset-binary conversion used by the modulator.
package tqvp_pdm_pkg;

   localparam int SAMPLE_W_DEF = 16;

   localparam logic [3:0] ADDR_CTRL     = 4'h0;
   localparam logic [3:0] ADDR_PRESC    = 4'h1;
   localparam logic [3:0] ADDR_STATUS   = 4'h2;
   localparam logic [3:0] ADDR_LEVEL_LO = 4'h3;
   localparam logic [3:0] ADDR_LEVEL_HI = 4'h4;

   localparam int CTRL_W         = 5;
   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_INV_BIT   = 1;
   localparam int CTRL_SHIFT_LSB = 2;
   localparam int CTRL_SHIFT_MSB = 4;

   localparam logic [15:0] LEVEL_MID = 16'h8000;

   function automatic logic [15:0] to_offset_binary(input logic [15:0] v);
      return v ^ LEVEL_MID;
   endfunction

endpackage

// File: rtl/tqvp_pdm_sat.sv
// Combinational shift-and-saturate: scales a signed sample by 2^shift, clamps
// to the 16-bit signed range and returns it as an offset-binary level.
module tqvp_pdm_sat
   import tqvp_pdm_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [2:0]          shift,
   output logic [15:0]         level
);

   // Wide enough that a shift of up to 7 never loses the sign bit.
   localparam int WIDE_W = (SAMPLE_W + 8 > 17) ? SAMPLE_W + 8 : 17;

   logic signed [WIDE_W-1:0] ext_s;
   logic signed [WIDE_W-1:0] shifted_s;
   logic [WIDE_W-16:0]       upper_s;

   // Scale, detect overflow of the 16-bit signed range, then clamp.
   always_comb begin
      ext_s     = {{(WIDE_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
      shifted_s = ext_s <<< shift;
      upper_s   = shifted_s[WIDE_W-1:15];
      if ((&upper_s) || !(|upper_s)) begin
         level = to_offset_binary(shifted_s[15:0]);
      end else if (shifted_s[WIDE_W-1]) begin
         level = to_offset_binary(16'h8000);
      end else begin
         level = to_offset_binary(16'h7FFF);
      end
   end

endmodule

// File: rtl/tqvp_pdm_out.sv
// PDM audio output peripheral: one-entry sample holding register, prescaled
// tick generator and a first-order accumulator modulator behind a byte register map.
module tqvp_pdm_out
   import tqvp_pdm_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic [3:0]          address,
   input  logic [7:0]          data_in,
   input  logic                data_write,
   output logic [7:0]          data_out,
   output logic                pdm_out
);

   logic [CTRL_W-1:0] ctrl_r;
   logic [7:0]        presc_r;
   logic [7:0]        cnt_r;
   logic              full_r;
   logic              underrun_r;
   logic              load_seen_r;
   logic              ready_r;
   logic              pdm_r;
   logic [15:0]       hold_r;
   logic [15:0]       level_r;
   logic [15:0]       acc_r;

   logic              en_s;
   logic              inv_s;
   logic [2:0]        shift_s;
   logic              wr_ctrl_s;
   logic              wr_presc_s;
   logic              wr_status_s;
   logic              tick_s;
   logic              xfer_s;
   logic              load_s;
   logic              full_next_s;
   logic [7:0]        cnt_next_s;
   logic [15:0]       sat_level_s;
   logic [15:0]       eff_level_s;
   logic [16:0]       sum_s;

   tqvp_pdm_sat #(
      .SAMPLE_W(SAMPLE_W)
   ) u_sat (
      .sample(sample_data),
      .shift (shift_s),
      .level (sat_level_s)
   );

   // Write decode, tick generation, holding-register handshake and modulator sum.
   always_comb begin
      en_s        = ctrl_r[CTRL_EN_BIT];
      inv_s       = ctrl_r[CTRL_INV_BIT];
      shift_s     = ctrl_r[CTRL_SHIFT_MSB:CTRL_SHIFT_LSB];
      wr_ctrl_s   = data_write && (address == ADDR_CTRL);
      wr_presc_s  = data_write && (address == ADDR_PRESC);
      wr_status_s = data_write && (address == ADDR_STATUS);
      tick_s      = en_s && !wr_presc_s && (cnt_r == presc_r);
      xfer_s      = sample_valid && ready_r;
      load_s      = tick_s && full_r;
      // A sample being promoted on this tick already drives the accumulator.
      eff_level_s = full_r ? hold_r : level_r;
      sum_s       = {1'b0, acc_r} + {1'b0, eff_level_s};
      if (!en_s || wr_presc_s || tick_s) begin
         cnt_next_s = 8'h00;
      end else begin
         cnt_next_s = cnt_r + 8'h01;
      end
      if (load_s) begin
         full_next_s = 1'b0;
      end else if (xfer_s) begin
         full_next_s = 1'b1;
      end else begin
         full_next_s = full_r;
      end
   end

   // Configuration, sample path, status flags and modulator state.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_r      <= '0;
         presc_r     <= 8'h00;
         cnt_r       <= 8'h00;
         full_r      <= 1'b0;
         underrun_r  <= 1'b0;
         load_seen_r <= 1'b0;
         ready_r     <= 1'b0;
         pdm_r       <= 1'b0;
         hold_r      <= 16'h0000;
         level_r     <= LEVEL_MID;
         acc_r       <= 16'h0000;
      end else begin
         if (wr_ctrl_s) begin
            ctrl_r <= data_in[CTRL_W-1:0];
         end
         if (wr_presc_s) begin
            presc_r <= data_in;
         end
         cnt_r   <= cnt_next_s;
         full_r  <= full_next_s;
         ready_r <= !full_next_s;
         if (xfer_s) begin
            hold_r <= sat_level_s;
         end
         if (load_s) begin
            level_r     <= hold_r;
            load_seen_r <= 1'b1;
         end
         // Setting on a starved tick takes priority over a software clear.
         if (tick_s && !full_r && load_seen_r) begin
            underrun_r <= 1'b1;
         end else if (wr_status_s) begin
            underrun_r <= 1'b0;
         end
         if (!en_s) begin
            acc_r <= 16'h0000;
            pdm_r <= inv_s;
         end else if (tick_s) begin
            acc_r <= sum_s[15:0];
            pdm_r <= sum_s[16] ^ inv_s;
         end
      end
   end

   // Register read mux.
   always_comb begin
      data_out = 8'h00;
      case (address)
         ADDR_CTRL:     data_out = {{(8-CTRL_W){1'b0}}, ctrl_r};
         ADDR_PRESC:    data_out = presc_r;
         ADDR_STATUS:   data_out = {6'b000000, underrun_r, full_r};
         ADDR_LEVEL_LO: data_out = level_r[7:0];
         ADDR_LEVEL_HI: data_out = level_r[15:8];
         default:       data_out = 8'h00;
      endcase
   end

   assign sample_ready = ready_r;
   assign pdm_out      = pdm_r;

endmodule

// File: tb/tb_tqvp_pdm_out.sv
// Self-checking bench for tqvp_pdm_out: an arithmetic reference model checked
// every cycle, plus directed sequences with hand-computed expectations.
module tb_tqvp_pdm_out;

   logic        clk;
   logic        rst;
   logic [15:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic [3:0]  address;
   logic [7:0]  data_in;
   logic        data_write;
   logic [7:0]  data_out;
   logic        pdm_out;

   int total = 0;
   int bad   = 0;

   tqvp_pdm_out #(
      .SAMPLE_W(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .address     (address),
      .data_in     (data_in),
      .data_write  (data_write),
      .data_out    (data_out),
      .pdm_out     (pdm_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_en = 1'b0, m_inv = 1'b0, m_full = 1'b0, m_under = 1'b0;
   bit m_seen = 1'b0, m_pdm = 1'b0, m_ready = 1'b0;
   int m_shift = 0, m_presc = 0, m_phase = 0;
   int m_hold = 0, m_level = 32768, m_acc = 0;

   // Level as an unsigned 0..65535 number: clamp(sample * 2^shift) + 32768.
   function automatic int sat_level(input logic [15:0] d, input int sh);
      int v;
      v = int'($signed(d)) * (1 << sh);
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return v + 32768;
   endfunction

   function automatic int m_read(input logic [3:0] a);
      case (a)
         4'h0: return (m_shift << 2) | (int'(m_inv) << 1) | int'(m_en);
         4'h1: return m_presc;
         4'h2: return (int'(m_under) << 1) | int'(m_full);
         4'h3: return m_level % 256;
         4'h4: return m_level / 256;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      bit wr_ctrl, wr_presc, wr_status, tick, xfer, starved;
      int lvl, sum;
      if (rst) begin
         m_en = 1'b0; m_inv = 1'b0; m_shift = 0; m_presc = 0;
         m_full = 1'b0; m_under = 1'b0; m_seen = 1'b0;
         m_level = 32768; m_acc = 0; m_phase = 0; m_pdm = 1'b0; m_ready = 1'b0;
      end else begin
         wr_ctrl   = data_write && (address == 4'h0);
         wr_presc  = data_write && (address == 4'h1);
         wr_status = data_write && (address == 4'h2);
         tick      = m_en && !wr_presc && (m_phase == m_presc);
         xfer      = sample_valid && m_ready;
         starved   = tick && !m_full && m_seen;
         lvl       = m_full ? m_hold : m_level;
         if (!m_en) begin
            m_acc = 0;
            m_pdm = m_inv;
         end else if (tick) begin
            sum   = m_acc + lvl;
            m_pdm = (sum >= 65536) != m_inv;
            m_acc = sum % 65536;
         end
         if (starved) m_under = 1'b1;
         else if (wr_status) m_under = 1'b0;
         if (tick && m_full) begin
            m_level = m_hold;
            m_seen  = 1'b1;
            m_full  = 1'b0;
         end else if (xfer) begin
            m_hold = sat_level(sample_data, m_shift);
            m_full = 1'b1;
         end
         m_ready = !m_full;
         if (!m_en || wr_presc || tick) m_phase = 0;
         else m_phase = m_phase + 1;
         if (wr_ctrl) begin
            m_en    = data_in[0];
            m_inv   = data_in[1];
            m_shift = int'(data_in[4:2]);
         end
         if (wr_presc) m_presc = int'(data_in);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("model_pdm_out", pdm_out, m_pdm);
         chk("model_sample_ready", sample_ready, m_ready);
         chk("model_data_out", data_out, m_read(address));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      @(negedge clk);
      data_write = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [3:0] a, input logic [7:0] req);
      address = a;
      #1;
      chk(nm, data_out, req);
   endtask

   task automatic send(input logic [15:0] s);
      sample_data  = s;
      sample_valid = 1'b1;
      for (int i = 0; i < 100 && !sample_ready; i++) @(negedge clk);
      chk("send_ready", sample_ready, 1'b1);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // ---------------- directed sequences ----------------
   initial begin
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_data  = 16'h0000;
      address      = 4'h0;
      data_in      = 8'h00;
      data_write   = 1'b0;
      @(negedge clk);

      // Reset state.
      for (int a = 0; a < 5; a++) begin
         rd("rst_read", 4'(a), (a == 4) ? 8'h80 : 8'h00);
         chk("rst_pdm", pdm_out, 1'b0);
         chk("rst_ready", sample_ready, 1'b0);
         step(1);
      end
      rst = 1'b0;
      step(1);
      chk("ready_after_rst", sample_ready, 1'b1);

      // Mid-scale level toggles every tick.
      wr(4'h1, 8'h03);
      send(16'h0000);
      rd("mid_full_before_en", 4'h2, 8'h01);
      wr(4'h0, 8'h01);
      step(3);
      rd("mid_full_pre_tick", 4'h2, 8'h01);
      chk("mid_pdm_pre_tick", pdm_out, 1'b0);
      step(1);
      rd("mid_full_cleared", 4'h2, 8'h00);
      chk("mid_ready_back", sample_ready, 1'b1);
      step(3);
      chk("mid_pdm_n8", pdm_out, 1'b0);
      step(1);
      chk("mid_pdm_n9", pdm_out, 1'b1);
      step(3);
      chk("mid_pdm_n12", pdm_out, 1'b1);
      step(1);
      chk("mid_pdm_n13", pdm_out, 1'b0);
      step(4);
      chk("mid_pdm_n17", pdm_out, 1'b1);

      // Shift with saturation to both rails.
      wr(4'h0, 8'h09);
      send(16'h4000);
      step(6);
      rd("sat_hi_lo", 4'h3, 8'hFF);
      rd("sat_hi_hi", 4'h4, 8'hFF);
      step(1);
      send(16'hC000);
      step(6);
      rd("sat_lo_lo", 4'h3, 8'h00);
      rd("sat_lo_hi", 4'h4, 8'h00);
      for (int i = 0; i < 12; i++) begin
         chk("zero_level_pdm", pdm_out, 1'b0);
         step(1);
      end

      // Underrun: sticky, cleared by write, set wins on same-cycle tick.
      wr(4'h0, 8'h00);
      wr(4'h2, 8'h00);
      rd("und_cleared", 4'h2, 8'h00);
      wr(4'h1, 8'h00);
      send(16'h1234);
      wr(4'h0, 8'h01);
      rd("und_full", 4'h2, 8'h01);
      step(1);
      rd("und_first_tick", 4'h2, 8'h00);
      step(1);
      rd("und_second_tick", 4'h2, 8'h02);
      wr(4'h2, 8'h00);
      rd("und_set_wins", 4'h2, 8'h02);

      // PRESC rewritten while the counter sits at 5.
      wr(4'h0, 8'h00);
      wr(4'h2, 8'h00);
      wr(4'h1, 8'h09);
      send(16'h0000);
      wr(4'h0, 8'h01);
      step(5);
      wr(4'h1, 8'h02);
      step(2);
      rd("presc_no_early_tick", 4'h2, 8'h01);
      step(1);
      rd("presc_tick_3clk", 4'h2, 8'h00);

      // Inversion while disabled, then reset with a full holding register.
      wr(4'h0, 8'h02);
      step(1);
      chk("inv_idle_pdm", pdm_out, 1'b1);
      send(16'h1000);
      rd("inv_full", 4'h2, 8'h01);
      rst          = 1'b1;
      sample_data  = 16'h7777;
      sample_valid = 1'b1;
      step(1);
      rst          = 1'b0;
      sample_valid = 1'b0;
      rd("rst2_status", 4'h2, 8'h00);
      chk("rst2_ready_low", sample_ready, 1'b0);
      step(1);
      rd("rst2_level_hi", 4'h4, 8'h80);
      chk("rst2_ready_high", sample_ready, 1'b1);
      rd("rst2_level_lo", 4'h3, 8'h00);
      step(1);
      rd("rst2_ctrl", 4'h0, 8'h00);
      chk("rst2_pdm", pdm_out, 1'b0);
      wr(4'h1, 8'h03);
      send(16'h0000);
      wr(4'h0, 8'h01);
      step(3);
      rd("rst2_no_early_tick", 4'h2, 8'h01);
      step(1);
      rd("rst2_first_tick", 4'h2, 8'h00);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
